// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the NOP word,
// instruction field bit ranges and the PC increment.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INC    = 32'd4;

    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bundle between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if;
    // Handshake: a request transfers on any cycle where req and ready are both
    // high; addr is held stable while req is high and ready is low. rvalid marks
    // one response word in rdata and has no back-pressure.
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input ready, input rvalid, input rdata);
    modport slave  (input req, input addr, output ready, output rvalid, output rdata);
endinterface

// File: rtl/fetch_perf_counter.sv
// Fetch performance counters: instructions handed to decode and memory stall
// cycles. Only built when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetched_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (fetched_inc) perf_fetched <= perf_fetched + 32'd1;
            if (stall_inc)   perf_stall   <= perf_stall + 32'd1;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM, instruction holding
// register and decoded register indices. FETCH_PERF_CNT_EN adds perf counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_unit_if.master       imem,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     dec_ready,
    output logic                     instr_valid,
    output logic [31:0]              instr,
    output logic [31:0]              pc_out,
    output logic [4:0]               rs1,
    output logic [4:0]               rs2,
    output logic [4:0]               rd,
    output logic [6:0]               opcode,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]              perf_fetched,
    output logic [31:0]              perf_stall,
`endif
    output riscv_pkg::fetch_state_e  fetch_state
);
    import riscv_pkg::*;

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  instr_q, instr_n;
    logic [31:0]  pc_out_q, pc_out_n;
    logic         valid_q, valid_n;
    logic         drop, drop_n;

    // Word alignment discards the low target bits.
    logic [1:0] unused_redirect_lsbs;
    assign unused_redirect_lsbs = redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_out_q <= RESET_PC;
            valid_q  <= 1'b0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr_q  <= instr_n;
            pc_out_q <= pc_out_n;
            valid_q  <= valid_n;
            drop     <= drop_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        instr_n  = instr_q;
        pc_out_n = pc_out_q;
        valid_n  = valid_q;
        drop_n   = drop;
        if (redirect_valid) begin
            // A redirect beats every other event; an accepted-but-unanswered
            // request must still drain, so its response is marked for discard.
            pc_n    = {redirect_pc[31:2], 2'b00};
            valid_n = 1'b0;
            case (state)
                IDLE: state_n = IDLE;
                REQ: begin
                    if (imem.ready) begin
                        state_n = WAIT;
                        drop_n  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        state_n = REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end
                HOLD: state_n = REQ;
                default: state_n = IDLE;
            endcase
        end else begin
            case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (imem.ready) state_n = WAIT;
                end
                WAIT: begin
                    if (imem.rvalid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = REQ;
                        end else begin
                            instr_n  = imem.rdata;
                            pc_out_n = pc;
                            valid_n  = 1'b1;
                            state_n  = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        pc_n    = pc + PC_INC;
                        valid_n = 1'b0;
                        state_n = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign imem.req    = (state == REQ);
    assign imem.addr   = pc;
    assign fetch_state = state;

    // Invalid slots present a NOP with zeroed indices so the register file reads x0.
    assign instr_valid = valid_q;
    assign instr       = valid_q ? instr_q : NOP_INSTR;
    assign pc_out      = pc_out_q;
    assign rs1         = valid_q ? instr_q[RS1_MSB:RS1_LSB] : 5'd0;
    assign rs2         = valid_q ? instr_q[RS2_MSB:RS2_LSB] : 5'd0;
    assign rd          = valid_q ? instr_q[RD_MSB:RD_LSB]   : 5'd0;
    assign opcode      = instr[OPC_MSB:OPC_LSB];

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf (
        .clk          (clk),
        .reset        (reset),
        .fetched_inc  ((state == HOLD) && dec_ready && !redirect_valid),
        .stall_inc    (((state == REQ) && !imem.ready) || ((state == WAIT) && !imem.rvalid)),
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
    );
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; define FETCH_PERF_CNT_EN to also
// exercise the performance counters.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic [4:0]  rs1, rs2, rd;
    logic [6:0]  opcode;
    fetch_state_e fetch_state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    instr_fetch_unit_if imem ();

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem           (imem.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_ready      (dec_ready),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc_out         (pc_out),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .opcode         (opcode),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .fetch_state    (fetch_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem.ready     = 1'b0;
        imem.rvalid    = 1'b0;
        imem.rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        dec_ready      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem.req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out: got %h want 0", pc_out); end
        checks++; if ({rs1, rs2, rd} !== 15'd0) begin errors++; $display("FAIL reset_fields: got %h want 0", {rs1, rs2, rd}); end
        checks++; if (fetch_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", fetch_state); end
        reset = 1'b0;
        step();
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0) begin errors++; $display("FAIL first_req: req=%b addr=%h want 1/0", imem.req, imem.addr); end
    endtask

    task automatic test_basic_fetch();
        imem.ready = 1'b1;
        step();
        imem.ready = 1'b0;
        checks++; if (fetch_state !== WAIT || imem.req !== 1'b0) begin errors++; $display("FAIL basic_wait: state=%0d req=%b want WAIT/0", fetch_state, imem.req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", instr_valid); end
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h00A3_0293;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h00A3_0293 || pc_out !== 32'h0) begin errors++; $display("FAIL basic_hold: valid=%b instr=%h pc=%h want 1/00a30293/0", instr_valid, instr, pc_out); end
        checks++; if (rs1 !== 5'd6 || rs2 !== 5'd10 || rd !== 5'd5 || opcode !== 7'h13) begin errors++; $display("FAIL basic_fields: rs1=%0d rs2=%0d rd=%0d op=%h want 6/10/5/13", rs1, rs2, rd, opcode); end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin errors++; $display("FAIL basic_next_addr: req=%b addr=%h want 1/4", imem.req, imem.addr); end
        checks++; if (instr_valid !== 1'b0 || rs1 !== 5'd0 || instr !== 32'h13) begin errors++; $display("FAIL basic_consumed: valid=%b rs1=%0d instr=%h want 0/0/13", instr_valid, rs1, instr); end
    endtask

    task automatic test_stall_hold();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h4) begin errors++; $display("FAIL stall_req%0d: req=%b addr=%h want 1/4", i, imem.req, imem.addr); end
        end
        imem.ready = 1'b1;
        step();
        imem.ready  = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0041_8533;
        step();
        imem.rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (instr_valid !== 1'b1 || instr !== 32'h0041_8533 || pc_out !== 32'h4) begin errors++; $display("FAIL hold%0d_instr: valid=%b instr=%h pc=%h want 1/00418533/4", i, instr_valid, instr, pc_out); end
            checks++; if (rs1 !== 5'd3 || rs2 !== 5'd4 || rd !== 5'd10 || opcode !== 7'h33) begin errors++; $display("FAIL hold%0d_fields: rs1=%0d rs2=%0d rd=%0d op=%h want 3/4/10/33", i, rs1, rs2, rd, opcode); end
        end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        checks++; if (imem.addr !== 32'h8 || imem.req !== 1'b1) begin errors++; $display("FAIL stall_next_addr: addr=%h req=%b want 8/1", imem.addr, imem.req); end
    endtask

    task automatic test_redirect_wait();
        imem.ready = 1'b1;
        step();
        imem.ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_state !== WAIT || imem.req !== 1'b0) begin errors++; $display("FAIL rdw_wait: state=%0d req=%b want WAIT/0", fetch_state, imem.req); end
        step();
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hDEAD_BEEF;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h100) begin errors++; $display("FAIL rdw_drop: valid=%b req=%b addr=%h want 0/1/100", instr_valid, imem.req, imem.addr); end
        imem.ready = 1'b1;
        step();
        imem.ready  = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0000_0093;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b1 || pc_out !== 32'h100 || instr !== 32'h93) begin errors++; $display("FAIL rdw_target: valid=%b pc=%h instr=%h want 1/100/93", instr_valid, pc_out, instr); end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
    endtask

    task automatic test_redirect_handshake();
        imem.ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        imem.ready     = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (fetch_state !== WAIT || imem.addr !== 32'h200) begin errors++; $display("FAIL rdh_wait: state=%0d addr=%h want WAIT/200", fetch_state, imem.addr); end
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h1234_5678;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem.req !== 1'b1 || imem.addr !== 32'h200) begin errors++; $display("FAIL rdh_drop: valid=%b req=%b addr=%h want 0/1/200", instr_valid, imem.req, imem.addr); end
    endtask

    task automatic test_redirect_hold_wrap();
        imem.ready = 1'b1;
        step();
        imem.ready  = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0000_0113;
        step();
        imem.rvalid = 1'b0;
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        step();
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        checks++; if (imem.addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0 || rd !== 5'd0) begin errors++; $display("FAIL rhold_addr: addr=%h valid=%b rd=%0d want fffffffc/0/0", imem.addr, instr_valid, rd); end
        imem.ready = 1'b1;
        step();
        imem.ready  = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h0000_0193;
        step();
        imem.rvalid = 1'b0;
        checks++; if (pc_out !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin errors++; $display("FAIL wrap_pc_out: pc=%h valid=%b want fffffffc/1", pc_out, instr_valid); end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem.addr); end
    endtask

    task automatic test_reset_midflight();
        imem.ready = 1'b1;
        step();
        imem.ready = 1'b0;
        reset      = 1'b1;
        step();
        reset       = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'hCAFE_0013;
        step();
        imem.rvalid = 1'b0;
        checks++; if (instr_valid !== 1'b0 || imem.addr !== 32'h0 || fetch_state !== REQ) begin errors++; $display("FAIL rst_wait: valid=%b addr=%h state=%0d want 0/0/REQ", instr_valid, imem.addr, fetch_state); end
        step();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_late_valid: got %b want 0", instr_valid); end
        reset = 1'b1;
        step();
        reset          = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        checks++; if (fetch_state !== IDLE || imem.req !== 1'b0) begin errors++; $display("FAIL rdi_idle: state=%0d req=%b want IDLE/0", fetch_state, imem.req); end
        step();
        checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h40) begin errors++; $display("FAIL rdi_addr: req=%b addr=%h want 1/40", imem.req, imem.addr); end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                step();
                step();
            end
            imem.ready = 1'b1;
            step();
            imem.ready  = 1'b0;
            imem.rvalid = 1'b1;
            imem.rdata  = 32'h0000_0013;
            step();
            imem.rvalid = 1'b0;
            dec_ready   = 1'b1;
            step();
            dec_ready   = 1'b0;
        end
        checks++; if (perf_fetched !== 32'd3) begin errors++; $display("FAIL perf_fetched: got %0d want 3", perf_fetched); end
        checks++; if (perf_stall !== 32'd2) begin errors++; $display("FAIL perf_stall: got %0d want 2", perf_stall); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_handshake();
        test_redirect_hold_wrap();
        test_reset_midflight();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
